// File: rtl/uart_frame_decoder.sv
`default_nettype none
// ============================================================================
// Module   : uart_frame_decoder
// Purpose  : Splits the byte stream from the UART receiver into framed
//            packets of the form SYNC, LEN, LEN payload bytes, CHK. Payload
//            bytes are forwarded as soon as they arrive. The CHK byte then
//            produces a good/bad frame pulse. An inter-byte timeout inside a
//            frame recovers from line noise and from a sender that stalls.
// Ports    : sys_clk        in   1   system clock
//            sys_nrst       in   1   synchronous active-low reset
//            rx_valid       in   1   one-cycle strobe, rx_data holds a byte
//            rx_data        in   8   received byte
//            pld_valid      out  1   payload byte strobe (no backpressure)
//            pld_data       out  8   payload byte
//            pld_first      out  1   first payload byte of the frame
//            pld_last       out  1   last payload byte of the frame
//            frame_ok       out  1   pulse: checksum correct
//            frame_err      out  1   pulse: frame aborted
//            err_code       out  2   1 LEN==0, 2 bad CHK, 3 timeout (held)
//            busy           out  1   decoder is inside a frame
//            frames_ok_cnt  out 16   saturating good-frame count (option)
//            frames_err_cnt out 16   saturating bad-frame count (option)
// Options  : UART_FRAME_STATS_EN - when defined, adds the two frame counters.
// Revision : 1.0  initial release
// ============================================================================
module uart_frame_decoder #(
    parameter logic [7:0] SYNC_BYTE   = 8'hA5,
    parameter int         TIMEOUT_CYC = 100000
) (
    input  logic        sys_clk,
    input  logic        sys_nrst,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        pld_valid,
    output logic [7:0]  pld_data,
    output logic        pld_first,
    output logic        pld_last,
    output logic        frame_ok,
    output logic        frame_err,
    output logic [1:0]  err_code,
    output logic        busy
`ifdef UART_FRAME_STATS_EN
    ,
    output logic [15:0] frames_ok_cnt,
    output logic [15:0] frames_err_cnt
`endif
);

    localparam logic [1:0] c_ST_HUNT    = 2'd0;
    localparam logic [1:0] c_ST_LEN     = 2'd1;
    localparam logic [1:0] c_ST_PAYLOAD = 2'd2;
    localparam logic [1:0] c_ST_CHK     = 2'd3;

    localparam int              c_TO_W    = $clog2(TIMEOUT_CYC);
    localparam logic [c_TO_W-1:0] c_TO_LAST = c_TO_W'(TIMEOUT_CYC - 1);

    localparam logic [1:0] c_ERR_LEN0 = 2'd1;
    localparam logic [1:0] c_ERR_CHK  = 2'd2;
    localparam logic [1:0] c_ERR_TO   = 2'd3;

    logic [1:0]        state_q,     state_d;
    logic [7:0]        remain_q,    remain_d;
    logic [7:0]        sum_q,       sum_d;
    logic              first_pend_q, first_pend_d;
    logic [c_TO_W-1:0] to_cnt_q,    to_cnt_d;

    logic              pld_valid_q, pld_valid_d;
    logic [7:0]        pld_data_q,  pld_data_d;
    logic              pld_first_q, pld_first_d;
    logic              pld_last_q,  pld_last_d;
    logic              frame_ok_q,  frame_ok_d;
    logic              frame_err_q, frame_err_d;
    logic [1:0]        err_code_q,  err_code_d;

    logic [7:0]        w_sum_next;
    logic              w_timeout;

    assign w_sum_next = sum_q + rx_data;
    // A byte arriving in the expiry cycle wins over the timeout.
    assign w_timeout  = (state_q != c_ST_HUNT) && !rx_valid && (to_cnt_q == c_TO_LAST);

    always_comb begin
        state_d      = state_q;
        remain_d     = remain_q;
        sum_d        = sum_q;
        first_pend_d = first_pend_q;
        pld_valid_d  = 1'b0;
        pld_data_d   = pld_data_q;
        pld_first_d  = 1'b0;
        pld_last_d   = 1'b0;
        frame_ok_d   = 1'b0;
        frame_err_d  = 1'b0;
        err_code_d   = err_code_q;

        if (state_q == c_ST_HUNT || rx_valid) begin
            to_cnt_d = '0;
        end else begin
            to_cnt_d = to_cnt_q + 1'b1;
        end

        case (state_q)
            c_ST_HUNT: begin
                if (rx_valid && rx_data == SYNC_BYTE) begin
                    state_d = c_ST_LEN;
                end
            end
            c_ST_LEN: begin
                if (rx_valid) begin
                    if (rx_data == 8'd0) begin
                        frame_err_d = 1'b1;
                        err_code_d  = c_ERR_LEN0;
                        state_d     = c_ST_HUNT;
                    end else begin
                        remain_d     = rx_data;
                        sum_d        = rx_data;
                        first_pend_d = 1'b1;
                        state_d      = c_ST_PAYLOAD;
                    end
                end
            end
            c_ST_PAYLOAD: begin
                if (rx_valid) begin
                    pld_valid_d  = 1'b1;
                    pld_data_d   = rx_data;
                    pld_first_d  = first_pend_q;
                    pld_last_d   = (remain_q == 8'd1);
                    first_pend_d = 1'b0;
                    sum_d        = w_sum_next;
                    remain_d     = remain_q - 8'd1;
                    if (remain_q == 8'd1) begin
                        state_d = c_ST_CHK;
                    end
                end
            end
            c_ST_CHK: begin
                if (rx_valid) begin
                    if (w_sum_next == 8'd0) begin
                        frame_ok_d  = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                        err_code_d  = c_ERR_CHK;
                    end
                    state_d = c_ST_HUNT;
                end
            end
            default: begin
                state_d = c_ST_HUNT;
            end
        endcase

        if (w_timeout) begin
            frame_err_d = 1'b1;
            err_code_d  = c_ERR_TO;
            state_d     = c_ST_HUNT;
            to_cnt_d    = '0;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_nrst) begin
            state_q      <= c_ST_HUNT;
            remain_q     <= 8'd0;
            sum_q        <= 8'd0;
            first_pend_q <= 1'b0;
            to_cnt_q     <= '0;
            pld_valid_q  <= 1'b0;
            pld_data_q   <= 8'd0;
            pld_first_q  <= 1'b0;
            pld_last_q   <= 1'b0;
            frame_ok_q   <= 1'b0;
            frame_err_q  <= 1'b0;
            err_code_q   <= 2'd0;
        end else begin
            state_q      <= state_d;
            remain_q     <= remain_d;
            sum_q        <= sum_d;
            first_pend_q <= first_pend_d;
            to_cnt_q     <= to_cnt_d;
            pld_valid_q  <= pld_valid_d;
            pld_data_q   <= pld_data_d;
            pld_first_q  <= pld_first_d;
            pld_last_q   <= pld_last_d;
            frame_ok_q   <= frame_ok_d;
            frame_err_q  <= frame_err_d;
            err_code_q   <= err_code_d;
        end
    end

    assign pld_valid = pld_valid_q;
    assign pld_data  = pld_data_q;
    assign pld_first = pld_first_q;
    assign pld_last  = pld_last_q;
    assign frame_ok  = frame_ok_q;
    assign frame_err = frame_err_q;
    assign err_code  = err_code_q;
    assign busy      = (state_q != c_ST_HUNT);

`ifdef UART_FRAME_STATS_EN
    logic [15:0] ok_cnt_q;
    logic [15:0] err_cnt_q;

    // Counts follow the registered pulses, so they settle one cycle later.
    always_ff @(posedge sys_clk) begin
        if (!sys_nrst) begin
            ok_cnt_q  <= 16'd0;
            err_cnt_q <= 16'd0;
        end else begin
            if (frame_ok_q && ok_cnt_q != 16'hFFFF) begin
                ok_cnt_q <= ok_cnt_q + 16'd1;
            end
            if (frame_err_q && err_cnt_q != 16'hFFFF) begin
                err_cnt_q <= err_cnt_q + 16'd1;
            end
        end
    end

    assign frames_ok_cnt  = ok_cnt_q;
    assign frames_err_cnt = err_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_frame_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_frame_decoder
// Purpose  : Self-checking bench for uart_frame_decoder. The directed steps
//            push expected output events into a scoreboard queue. A monitor
//            pops an event each time the decoder emits a payload byte or a
//            frame pulse, and compares the two.
// Revision : 1.0  initial release
// ============================================================================
module tb_uart_frame_decoder;

    localparam int TO = 16;

    localparam logic [1:0] c_K_PLD = 2'd0;
    localparam logic [1:0] c_K_OK  = 2'd1;
    localparam logic [1:0] c_K_ERR = 2'd2;

    typedef struct packed {
        logic [1:0] kind;
        logic [7:0] data;
        logic       first;
        logic       last;
        logic [1:0] code;
    } evt_t;

    logic       sys_clk  = 1'b0;
    logic       sys_nrst = 1'b0;
    logic       rx_valid = 1'b0;
    logic [7:0] rx_data  = 8'd0;
    logic       pld_valid;
    logic [7:0] pld_data;
    logic       pld_first;
    logic       pld_last;
    logic       frame_ok;
    logic       frame_err;
    logic [1:0] err_code;
    logic       busy;
`ifdef UART_FRAME_STATS_EN
    logic [15:0] frames_ok_cnt;
    logic [15:0] frames_err_cnt;
`endif

    int   checks   = 0;
    int   failures = 0;
    int   ok_seen  = 0;
    evt_t exp_q[$];

    uart_frame_decoder #(
        .SYNC_BYTE   (8'hA5),
        .TIMEOUT_CYC (TO)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_nrst  (sys_nrst),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .pld_valid (pld_valid),
        .pld_data  (pld_data),
        .pld_first (pld_first),
        .pld_last  (pld_last),
        .frame_ok  (frame_ok),
        .frame_err (frame_err),
        .err_code  (err_code),
        .busy      (busy)
`ifdef UART_FRAME_STATS_EN
        ,
        .frames_ok_cnt  (frames_ok_cnt),
        .frames_err_cnt (frames_err_cnt)
`endif
    );

    always #5 sys_clk = ~sys_clk;

    // Scoreboard monitor: every emitted event must match the queue head.
    always @(negedge sys_clk) begin
        if (pld_valid || frame_ok || frame_err) begin
            evt_t obs;
            evt_t exp;
            obs.kind  = pld_valid ? c_K_PLD : (frame_ok ? c_K_OK : c_K_ERR);
            obs.data  = pld_valid ? pld_data  : 8'd0;
            obs.first = pld_valid ? pld_first : 1'b0;
            obs.last  = pld_valid ? pld_last  : 1'b0;
            obs.code  = frame_err ? err_code  : 2'd0;
            if (frame_ok) ok_seen++;
            checks++;
            assert (!(frame_ok && frame_err)) else begin
                failures++;
                $error("FAIL ok_err_exclusive observed ok=%0b err=%0b expected not both", frame_ok, frame_err);
            end
            checks++;
            assert (exp_q.size() != 0) else begin
                failures++;
                $error("FAIL unexpected_event observed %h expected none", obs);
            end
            if (exp_q.size() != 0) begin
                exp = exp_q.pop_front();
                checks++;
                assert (obs === exp) else begin
                    failures++;
                    $error("FAIL scoreboard observed kind=%0d data=%h f=%0b l=%0b code=%0d expected kind=%0d data=%h f=%0b l=%0b code=%0d",
                           obs.kind, obs.data, obs.first, obs.last, obs.code,
                           exp.kind, exp.data, exp.first, exp.last, exp.code);
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_pld(input logic [7:0] d, input logic f, input logic l);
        exp_q.push_back('{kind: c_K_PLD, data: d, first: f, last: l, code: 2'd0});
    endtask

    task automatic push_ok();
        exp_q.push_back('{kind: c_K_OK, data: 8'd0, first: 1'b0, last: 1'b0, code: 2'd0});
    endtask

    task automatic push_err(input logic [1:0] code);
        exp_q.push_back('{kind: c_K_ERR, data: 8'd0, first: 1'b0, last: 1'b0, code: code});
    endtask

    task automatic send(input logic [7:0] b);
        @(posedge sys_clk);
        #1;
        rx_valid = 1'b1;
        rx_data  = b;
    endtask

    task automatic idle();
        @(posedge sys_clk);
        #1;
        rx_valid = 1'b0;
        rx_data  = 8'd0;
    endtask

    task automatic settle(input string tag);
        repeat (4) idle();
        chk(tag, exp_q.size(), 0);
    endtask

    // Complete good frame with payload seed + 37*i and the matching checksum.
    task automatic good_frame(input int len, input logic [7:0] seed);
        logic [7:0] s;
        logic [7:0] d;
        s = 8'(len);
        send(8'hA5);
        send(8'(len));
        for (int i = 0; i < len; i++) begin
            d = seed + 8'(i * 37);
            push_pld(d, i == 0, i == len - 1);
            send(d);
            s = s + d;
        end
        push_ok();
        send(8'd0 - s);
    endtask

    initial begin
        int seen;
        int ok_base;

        // Reset state
        repeat (3) @(posedge sys_clk);
        #1;
        chk("rst_pld_valid", pld_valid, 0);
        chk("rst_pld_data",  pld_data, 0);
        chk("rst_frame_ok",  frame_ok, 0);
        chk("rst_frame_err", frame_err, 0);
        chk("rst_err_code",  err_code, 0);
        chk("rst_busy",      busy, 0);
        sys_nrst = 1'b1;

        // Good frame: LEN 3 + 11 22 33 = 0x69, so CHK = 0x97
        push_pld(8'h11, 1, 0);
        push_pld(8'h22, 0, 0);
        push_pld(8'h33, 0, 1);
        push_ok();
        send(8'hA5); send(8'h03); send(8'h11); send(8'h22); send(8'h33); send(8'h97);
        idle();
        chk("good_ok_latency", frame_ok, 1);
        chk("good_busy_after", busy, 0);
        settle("sb_empty_good");

        // Bad checksum
        push_pld(8'h10, 1, 0);
        push_pld(8'h20, 0, 1);
        push_err(2'd2);
        send(8'hA5); send(8'h02); send(8'h10);
        send(8'h20);
        idle();
        chk("bad_busy_in_chk", busy, 1);
        send(8'h00);
        idle();
        chk("bad_err_pulse", frame_err, 1);
        chk("bad_err_code",  err_code, 2);
        chk("bad_busy_after", busy, 0);
        settle("sb_empty_bad");

        // Noise, then LEN==0, then a one-byte frame whose payload is SYNC
        push_err(2'd1);
        send(8'h00); send(8'hFF); send(8'hA5); send(8'h00);
        idle();
        chk("len0_err_code", err_code, 1);
        push_pld(8'hA5, 1, 1);
        push_ok();
        send(8'hA5); send(8'h01); send(8'hA5); send(8'h5A);
        settle("sb_empty_len0");

        // Timeout after a partial frame
        push_pld(8'h01, 1, 0);
        push_err(2'd3);
        send(8'hA5); send(8'h04); send(8'h01);
        idle();
        seen = 0;
        for (int k = 1; k <= TO + 8; k++) begin
            @(negedge sys_clk);
            if (frame_err) begin
                seen = k;
                break;
            end
        end
        chk("timeout_latency", seen, TO + 1);
        chk("timeout_code", err_code, 3);
        chk("timeout_busy", busy, 0);
        good_frame(2, 8'h3C);
        settle("sb_empty_timeout");
        chk("err_code_held", err_code, 3);

        // Byte arriving in the expiry cycle is consumed, no timeout
        push_pld(8'h44, 1, 0);
        push_pld(8'h55, 0, 1);
        push_ok();
        send(8'hA5); send(8'h02);
        idle();
        repeat (TO - 2) @(posedge sys_clk);
        send(8'h44); send(8'h55);
        send(8'd0 - (8'h02 + 8'h44 + 8'h55));
        settle("sb_empty_expiry");

        // Back-to-back frames with rx_valid every cycle
        ok_base = ok_seen;
        good_frame(3, 8'h10);
        good_frame(4, 8'hA5);
        settle("sb_empty_b2b");
        chk("b2b_ok_pulses", ok_seen - ok_base, 2);

        // Reset in the middle of the payload
        push_pld(8'h01, 1, 0);
        push_pld(8'h02, 0, 0);
        send(8'hA5); send(8'h05); send(8'h01); send(8'h02);
        @(posedge sys_clk);
        #1;
        rx_valid = 1'b0;
        sys_nrst = 1'b0;
        @(posedge sys_clk);
        #1;
        sys_nrst = 1'b1;
        chk("midrst_pld_valid", pld_valid, 0);
        chk("midrst_frame_err", frame_err, 0);
        chk("midrst_err_code",  err_code, 0);
        chk("midrst_busy",      busy, 0);
`ifdef UART_FRAME_STATS_EN
        chk("midrst_ok_cnt",  frames_ok_cnt, 0);
        chk("midrst_err_cnt", frames_err_cnt, 0);
`endif
        good_frame(2, 8'h77);
        settle("sb_empty_midrst");
`ifdef UART_FRAME_STATS_EN
        chk("stats_ok_cnt",  frames_ok_cnt, 1);
        chk("stats_err_cnt", frames_err_cnt, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
